// File: rtl/branch_resolve.sv
// Branch resolver: resolves a conditional branch, reads/updates a 2-bit BHT, one-entry output register.
// Optional build macro BRANCH_RESOLVE_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_op_a,
    input  logic [XLEN-1:0] req_op_b,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_taken,
    output logic            rsp_pred,
    output logic            rsp_mispredict,
    output logic            rsp_illegal
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready.
    logic [1:0]      r_bht [BHT_DEPTH];
    logic            r_rsp_valid;
    logic            r_rsp_taken;
    logic            r_rsp_pred;
    logic            r_rsp_mispredict;
    logic            r_rsp_illegal;

    logic            w_accept;
    logic            w_rsp_hs;
    logic [IDX_W-1:0] w_idx;
    logic [XLEN:0]   w_diff;
    logic            w_eq;
    logic            w_ltu;
    logic            w_lt;
    logic            w_taken;
    logic            w_illegal;
    logic [1:0]      w_cnt;
    logic [1:0]      w_cnt_next;
    logic            w_pred;
    logic            w_unused_pc;

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;

    assign w_idx       = req_pc[IDX_W+1:2];
    assign w_unused_pc = ^{req_pc[XLEN-1:IDX_W+2], req_pc[1:0]};

    // Single unsigned subtract; the extra top bit is the borrow.
    assign w_diff = {1'b0, req_op_a} - {1'b0, req_op_b};
    assign w_eq   = (w_diff[XLEN-1:0] == '0);
    assign w_ltu  = w_diff[XLEN];
    assign w_lt   = (req_op_a[XLEN-1] != req_op_b[XLEN-1]) ? req_op_a[XLEN-1] : w_ltu;

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (req_funct3)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = !w_ltu;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_cnt  = r_bht[w_idx];
    assign w_pred = w_cnt[1];

    always_comb begin
        w_cnt_next = w_cnt;
        if (w_taken) begin
            if (w_cnt != 2'b11) begin
                w_cnt_next = w_cnt + 2'd1;
            end
        end else begin
            if (w_cnt != 2'b00) begin
                w_cnt_next = w_cnt - 2'd1;
            end
        end
    end

    // The table is written on the accepting edge, so a back-to-back request to
    // the same entry already sees the updated counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && !w_illegal) begin
            r_bht[w_idx] <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid      <= 1'b0;
            r_rsp_taken      <= 1'b0;
            r_rsp_pred       <= 1'b0;
            r_rsp_mispredict <= 1'b0;
            r_rsp_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid      <= 1'b1;
            r_rsp_taken      <= w_taken;
            r_rsp_pred       <= w_pred;
            r_rsp_mispredict <= !w_illegal && (w_taken ^ w_pred);
            r_rsp_illegal    <= w_illegal;
        end else if (w_rsp_hs) begin
            r_rsp_valid      <= 1'b0;
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_taken      = r_rsp_taken;
    assign rsp_pred       = r_rsp_pred;
    assign rsp_mispredict = r_rsp_mispredict;
    assign rsp_illegal    = r_rsp_illegal;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Only legal responses that actually leave the block are counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (w_rsp_hs && !r_rsp_illegal) begin
            if (r_stat_branches != 32'hFFFF_FFFF) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (r_rsp_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus random traffic against a behavioural model.
// Builds with or without BRANCH_RESOLVE_STATS_EN.
module tb_branch_resolve;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_op_a;
    logic [XLEN-1:0] req_op_b;
    logic [XLEN-1:0] req_pc;
    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_taken;
    logic            rsp_pred;
    logic            rsp_mispredict;
    logic            rsp_illegal;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispredicts;
`endif

    branch_resolve #(.XLEN(XLEN), .BHT_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_funct3     (req_funct3),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .req_pc         (req_pc),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_taken      (rsp_taken),
        .rsp_pred       (rsp_pred),
        .rsp_mispredict (rsp_mispredict),
        .rsp_illegal    (rsp_illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state: expected response {taken, pred, mispredict, illegal}
    logic [3:0] exp_q[$];
    int         bht_model [DEPTH];
    longint     m_branches;
    longint     m_mispredicts;
    int         n_checks;
    int         n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_illegal(input logic [2:0] f3);
        return (f3 == 3'd2) || (f3 == 3'd3);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) bht_model[i] = 1;
        m_branches    = 0;
        m_mispredicts = 0;
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model past the rising edge.
    task automatic cycle(output bit acc);
        bit         hs;
        bit         t;
        bit         il;
        bit         p;
        int         idx;
        logic [3:0] e;
        e = '0;
        idx = 0;
        @(negedge clk);
        check("req_ready", req_ready, (exp_q.size() == 0) || rsp_ready);
        check("rsp_valid", rsp_valid, exp_q.size() != 0);
        if (exp_q.size() != 0)
            check("rsp_fields", {rsp_taken, rsp_pred, rsp_mispredict, rsp_illegal}, exp_q[0]);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("stat_branches", stat_branches, m_branches);
        check("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
        hs  = (exp_q.size() != 0) && rsp_ready;
        acc = req_valid && ((exp_q.size() == 0) || rsp_ready);
        if (acc) begin
            idx = int'((req_pc >> 2) % DEPTH);
            t   = model_taken(req_funct3, req_op_a, req_op_b);
            il  = model_illegal(req_funct3);
            p   = bht_model[idx] >= 2;
            e   = {t, p, !il && (t != p), il};
        end
        @(posedge clk);
        #1;
        if (hs) begin
            if (!exp_q[0][0]) begin
                if (m_branches < 64'hFFFF_FFFF) m_branches++;
                if (exp_q[0][1] && m_mispredicts < 64'hFFFF_FFFF) m_mispredicts++;
            end
            void'(exp_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back(e);
            if (!e[0]) begin
                if (e[3]) bht_model[idx] = (bht_model[idx] < 3) ? bht_model[idx] + 1 : 3;
                else      bht_model[idx] = (bht_model[idx] > 0) ? bht_model[idx] - 1 : 0;
            end
        end
    endtask

    // Driver tasks
    task automatic set_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        req_funct3 = f3;
        req_op_a   = a;
        req_op_b   = b;
        req_pc     = pc;
    endtask

    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        bit acc;
        set_req(f3, a, b, pc);
        req_valid = 1'b1;
        cycle(acc);
        check("send_accepted", acc, 1'b1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    task automatic expect_rsp(input string tag, input bit t, input bit p, input bit m, input bit il);
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_taken"}, rsp_taken, t);
        check({tag, "_pred"}, rsp_pred, p);
        check({tag, "_mispredict"}, rsp_mispredict, m);
        check({tag, "_illegal"}, rsp_illegal, il);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_fields", {rsp_taken, rsp_pred, rsp_mispredict, rsp_illegal}, 4'b0000);
        check("rst_req_ready", req_ready, 1'b1);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("rst_stat_branches", stat_branches, 0);
        check("rst_stat_mispredicts", stat_mispredicts, 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        check("rst_req_ready_hold", req_ready, 1'b1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         acc;
        bit         pend;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] b;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        req_valid  = 1'b0;
        rsp_ready  = 1'b1;
        set_req(3'd0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // BEQ equal at pc 0x40: weakly-not-taken entry mispredicts, then entry is 10
        send(3'd0, 5, 5, 32'h40);
        expect_rsp("beq_first", 1, 0, 1, 0);
        send(3'd1, 5, 5, 32'h40);
        expect_rsp("bne_after", 0, 1, 1, 0);
        idle(1);

        // Signed vs unsigned compare on the same operands
        do_reset();
        send(3'd4, 32'hFFFF_FFFF, 1, 32'h100);
        expect_rsp("blt_neg", 1, 0, 1, 0);
        send(3'd6, 32'hFFFF_FFFF, 1, 32'h200);
        check("bltu_neg_taken", rsp_taken, 1'b0);
        idle(1);

        // Saturation and back-to-back same-index reads
        do_reset();
        send(3'd0, 7, 7, 32'h80);
        expect_rsp("b2b_1", 1, 0, 1, 0);
        send(3'd0, 7, 7, 32'h80);
        expect_rsp("b2b_2", 1, 1, 0, 0);
        send(3'd0, 7, 7, 32'h80);
        expect_rsp("b2b_3", 1, 1, 0, 0);
        send(3'd0, 7, 8, 32'h80);
        expect_rsp("b2b_4", 0, 1, 1, 0);
        send(3'd0, 7, 7, 32'h80);
        expect_rsp("b2b_5", 1, 1, 0, 0);
        idle(1);

        // Stall for four cycles with a waiting request, then drain
        set_req(3'd5, 3, 9, 32'h10);
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        cycle(acc);
        check("stall_first_acc", acc, 1'b1);
        set_req(3'd7, 9, 3, 32'h14);
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            check("stall_no_acc", acc, 1'b0);
        end
        rsp_ready = 1'b1;
        cycle(acc);
        check("release_acc", acc, 1'b1);
        set_req(3'd1, 1, 2, 32'h18);
        cycle(acc);
        check("release_acc2", acc, 1'b1);
        idle(2);

        // Illegal code leaves the entry untouched
        do_reset();
        send(3'd3, 4, 4, 32'h40);
        expect_rsp("illegal", 0, 0, 0, 1);
        send(3'd0, 4, 4, 32'h40);
        expect_rsp("after_illegal", 1, 0, 1, 0);
        send(3'd2, 0, 0, 32'h40);
        expect_rsp("illegal_010", 0, 1, 0, 1);
        idle(2);

        // Reset while a response is stalled
        rsp_ready = 1'b0;
        send(3'd0, 1, 1, 32'h44);
        idle(2);
        check("pre_reset_valid", rsp_valid, 1'b1);
        do_reset();
        rsp_ready = 1'b1;
        send(3'd0, 1, 1, 32'h44);
        expect_rsp("post_reset", 1, 0, 1, 0);
        idle(1);

        // Random traffic; a refused request is held unchanged until taken
        pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!pend) begin
                f3 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 3))
                    0: begin a = $urandom(); b = $urandom(); end
                    1: begin a = $urandom(); b = a; end
                    2: begin a = $urandom_range(0, 4); b = $urandom_range(0, 4); end
                    default: begin a = $urandom() | 32'h8000_0000; b = $urandom() & 32'h7FFF_FFFF; end
                endcase
                if ($urandom_range(0, 1) == 1) begin
                    logic [31:0] tmp;
                    tmp = a; a = b; b = tmp;
                end
                set_req(f3, a, b, 32'($urandom_range(0, 63)) << 2);
                req_valid = ($urandom_range(0, 3) != 0);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle(acc);
            pend = req_valid && !acc;
        end
        rsp_ready = 1'b1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter XLEN, default 32: operand and PC width; legal values 32 or 64.
REQ-002 Parameter BHT_DEPTH, default 16: number of 2-bit history counters; power of 2, 4..256.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1: request present.
REQ-006 Port req_ready, output, 1: request accepted this cycle when high together with req_valid.
REQ-007 Port req_funct3, input, 3: branch condition code.
REQ-008 Port req_op_a and req_op_b, input, XLEN each: compare operands.
REQ-009 Port req_pc, input, XLEN: branch PC, used for table index only.
REQ-010 Port rsp_valid, output, 1: response present.
REQ-011 Port rsp_ready, input, 1: consumer takes the response.
REQ-012 Port rsp_taken, output, 1: resolved outcome.
REQ-013 Port rsp_pred, output, 1: prediction from the table before update.
REQ-014 Port rsp_mispredict, output, 1: rsp_taken XOR rsp_pred; forced 0 when rsp_illegal is 1.
REQ-015 Port rsp_illegal, output, 1: funct3 is 010 or 011.

Function
REQ-016 Handshake: req_ready = !rsp_valid || rsp_ready, with a single-entry output register and no combinational path from req_* to rsp_*.
REQ-017 Latency: an accepted request appears on rsp_* on the next cycle; back-to-back throughput is 1 per cycle while rsp_ready is high.
REQ-018 Stall: rsp_* hold stable while rsp_valid && !rsp_ready.
REQ-019 rsp_valid clears after a response handshake with no new accept in the same cycle.
REQ-020 Compare uses one XLEN+1-bit subtract a-b:
- EQ = zero difference.
- LTU = borrow.
- LT = op_a MSB when the sign bits differ, else borrow.
REQ-021 Condition decode by funct3:
- 000 EQ, 001 !EQ, 100 LT, 101 !LT, 110 LTU, 111 !LTU.
- 010 and 011: taken=0, illegal=1.
REQ-022 Table index = req_pc[log2(BHT_DEPTH)+1:2].
REQ-023 rsp_pred is bit 1 of the counter read at accept time.
REQ-024 Counter update occurs on the accepting clock edge; legal requests only:
- taken: increment, saturating at 11.
- not taken: decrement, saturating at 00.
REQ-025 Illegal requests leave the table unchanged.
REQ-026 Back-to-back accepts to the same index: the second request reads the value already updated by the first.
REQ-027 Simultaneous response handshake and new accept in one cycle: rsp_valid stays 1 and the register loads the new result.

Reset
REQ-028 On reset assertion, immediately and asynchronously:
- rsp_valid=0, rsp_taken=0, rsp_pred=0, rsp_mispredict=0, rsp_illegal=0.
- All counters = 01 (weakly not taken).
REQ-029 Reset mid-stall discards the pending response.
REQ-030 req_ready is 1 during and after reset.

Configuration
REQ-031 Macro BRANCH_RESOLVE_STATS_EN defined adds:
- Output stat_branches, 32 bits: counts legal responses handshaked out.
- Output stat_mispredicts, 32 bits: counts those with rsp_mispredict=1.
- Both saturate at 0xFFFFFFFF and reset to 0.
REQ-032 Macro BRANCH_RESOLVE_STATS_EN undefined: both ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 Reset, then funct3=000, a=5, b=5, pc=0x40 -> next cycle rsp_valid=1, taken=1, pred=0, mispredict=1; counter[0] becomes 10.
REQ-034 funct3=100, a=0xFFFFFFFF, b=1 -> taken=1 (signed -1<1); funct3=110 with the same operands -> taken=0.
REQ-035 Three back-to-back taken BEQ at pc=0x80 -> pred sequence 0,1,1; counter saturates at 11; a fourth not-taken request -> pred=1, mispredict=1, counter becomes 10.
REQ-036 Hold rsp_ready=0 for 4 cycles with req_valid=1 -> req_ready=0, rsp_* stable; release -> one response per cycle, no loss or duplication.
REQ-037 funct3=011 -> rsp_illegal=1, taken=0, mispredict=0, table unchanged; with BRANCH_RESOLVE_STATS_EN defined, stat_branches is unchanged.
REQ-038 Assert reset while rsp_valid=1 and stalled -> rsp_valid=0 immediately; the following request at the same pc gives pred=0.
